// File: rtl/code_lock_param.sv
`default_nettype none
// ============================================================================
// Module      : code_lock_param
// Description : N-digit sequential code lock with failed-attempt lockout,
//               auto-relock timeout and in-field code programming.
// Revision    : 1.0 - initial release
// ============================================================================
module code_lock_param #(
    parameter int                            DIGIT_W      = 4,
    parameter int                            CODE_LEN     = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0]   DEFAULT_CODE = 16'h1234,
    parameter int                            MAX_FAILS    = 3,
    parameter int                            LOCKOUT_CYC  = 1000,
    parameter int                            UNLOCK_CYC   = 500
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enter,
    input  logic [DIGIT_W-1:0]               digit,
    input  logic                             prog,
    input  logic                             relock,
    output logic                             locked,
    output logic                             unlocked,
    output logic                             error,
    output logic                             lockout,
    output logic                             prog_mode,
    output logic [$clog2(CODE_LEN+1)-1:0]    progress,
    output logic [$clog2(MAX_FAILS+1)-1:0]   fail_cnt
);

    localparam int CODE_W  = CODE_LEN * DIGIT_W;
    localparam int SH_W    = CODE_W - DIGIT_W;
    localparam int PROG_W  = $clog2(CODE_LEN + 1);
    localparam int FAIL_W  = $clog2(MAX_FAILS + 1);
    localparam int MAX_CYC = (LOCKOUT_CYC > UNLOCK_CYC) ? LOCKOUT_CYC : UNLOCK_CYC;
    localparam int TMR_W   = $clog2(MAX_CYC + 1);
    localparam int SLOTS   = 1 << PROG_W;

    localparam logic [PROG_W-1:0] C_LAST_DIGIT = PROG_W'(CODE_LEN - 1);
    localparam logic [FAIL_W-1:0] C_FAIL_LAST  = FAIL_W'(MAX_FAILS - 1);
    localparam logic [FAIL_W-1:0] C_FAIL_MAX   = FAIL_W'(MAX_FAILS);
    // Timers hold "cycles remaining minus one" so expiry is a zero test.
    localparam logic [TMR_W-1:0]  C_LOCK_LOAD  = TMR_W'(LOCKOUT_CYC - 1);
    localparam logic [TMR_W-1:0]  C_UNLK_LOAD  = TMR_W'(UNLOCK_CYC - 1);

    localparam logic [1:0] S_ENTRY    = 2'd0;
    localparam logic [1:0] S_UNLOCKED = 2'd1;
    localparam logic [1:0] S_PROGRAM  = 2'd2;
    localparam logic [1:0] S_LOCKOUT  = 2'd3;

    logic [1:0]         r_state,    w_state_nx;
    logic [TMR_W-1:0]   r_timer,    w_timer_nx;
    logic [CODE_W-1:0]  r_code,     w_code_nx;
    logic [SH_W-1:0]    r_shadow,   w_shadow_nx;
    logic               r_mismatch, w_mismatch_nx;
    logic [PROG_W-1:0]  w_progress_nx;
    logic [FAIL_W-1:0]  w_fails_nx;
    logic               w_error_nx;
    logic               w_locked_nx, w_unlocked_nx, w_lockout_nx, w_prog_mode_nx;
    logic [SH_W-1:0]    w_shadow_shift;
    logic [DIGIT_W-1:0] w_code_digit [SLOTS];
    logic               w_digit_bad;
    logic               w_last;

    // Slot 0 is the most significant digit, i.e. the first one entered.
    genvar gi;
    generate
        for (gi = 0; gi < SLOTS; gi++) begin : g_digit
            if (gi < CODE_LEN) begin : g_used
                assign w_code_digit[gi] = r_code[(CODE_LEN-1-gi)*DIGIT_W +: DIGIT_W];
            end else begin : g_unused
                assign w_code_digit[gi] = '0;
            end
        end
        if (SH_W > DIGIT_W) begin : g_shift_wide
            assign w_shadow_shift = {r_shadow[SH_W-DIGIT_W-1:0], digit};
        end else begin : g_shift_narrow
            assign w_shadow_shift = digit;
        end
    endgenerate

    assign w_digit_bad = (digit != w_code_digit[progress]);
    assign w_last      = (progress == C_LAST_DIGIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_ENTRY;
            r_timer    <= '0;
            r_code     <= DEFAULT_CODE;
            r_shadow   <= '0;
            r_mismatch <= 1'b0;
            progress   <= '0;
            fail_cnt   <= '0;
            error      <= 1'b0;
            locked     <= 1'b1;
            unlocked   <= 1'b0;
            lockout    <= 1'b0;
            prog_mode  <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_timer    <= w_timer_nx;
            r_code     <= w_code_nx;
            r_shadow   <= w_shadow_nx;
            r_mismatch <= w_mismatch_nx;
            progress   <= w_progress_nx;
            fail_cnt   <= w_fails_nx;
            error      <= w_error_nx;
            locked     <= w_locked_nx;
            unlocked   <= w_unlocked_nx;
            lockout    <= w_lockout_nx;
            prog_mode  <= w_prog_mode_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_timer_nx    = r_timer;
        w_code_nx     = r_code;
        w_shadow_nx   = r_shadow;
        w_mismatch_nx = r_mismatch;
        w_progress_nx = progress;
        w_fails_nx    = fail_cnt;
        w_error_nx    = 1'b0;
        case (r_state)
            S_ENTRY: begin
                if (enter) begin
                    if (w_last) begin
                        w_progress_nx = '0;
                        w_mismatch_nx = 1'b0;
                        if (r_mismatch || w_digit_bad) begin
                            w_error_nx = 1'b1;
                            if (fail_cnt == C_FAIL_LAST) begin
                                w_fails_nx = C_FAIL_MAX;
                                w_state_nx = S_LOCKOUT;
                                w_timer_nx = C_LOCK_LOAD;
                            end else begin
                                w_fails_nx = fail_cnt + 1'b1;
                            end
                        end else begin
                            w_fails_nx = '0;
                            w_state_nx = S_UNLOCKED;
                            w_timer_nx = C_UNLK_LOAD;
                        end
                    end else begin
                        w_progress_nx = progress + 1'b1;
                        w_mismatch_nx = r_mismatch | w_digit_bad;
                    end
                end
            end
            S_LOCKOUT: begin
                if (r_timer == '0) begin
                    w_state_nx = S_ENTRY;
                    w_fails_nx = '0;
                end else begin
                    w_timer_nx = r_timer - 1'b1;
                end
            end
            S_UNLOCKED: begin
                if (relock || (r_timer == '0)) begin
                    w_state_nx = S_ENTRY;
                end else if (prog) begin
                    w_state_nx    = S_PROGRAM;
                    w_progress_nx = '0;
                end else begin
                    w_timer_nx = r_timer - 1'b1;
                end
            end
            default: begin
                // Programming: the unlock timer is deliberately left frozen here.
                if (relock) begin
                    w_state_nx    = S_ENTRY;
                    w_progress_nx = '0;
                end else if (enter) begin
                    w_shadow_nx = w_shadow_shift;
                    if (w_last) begin
                        w_code_nx     = {r_shadow, digit};
                        w_state_nx    = S_UNLOCKED;
                        w_timer_nx    = C_UNLK_LOAD;
                        w_progress_nx = '0;
                    end else begin
                        w_progress_nx = progress + 1'b1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        w_locked_nx    = (w_state_nx == S_ENTRY) || (w_state_nx == S_LOCKOUT);
        w_unlocked_nx  = (w_state_nx == S_UNLOCKED) || (w_state_nx == S_PROGRAM);
        w_lockout_nx   = (w_state_nx == S_LOCKOUT);
        w_prog_mode_nx = (w_state_nx == S_PROGRAM);
    end

endmodule
`default_nettype wire

// File: tb/tb_code_lock_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_code_lock_param
// Description : Vector table, directed corner sequences and random stimulus
//               against a queue-based reference model of the code lock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_code_lock_param;

    localparam int LOCKOUT_CYC = 1000;
    localparam int UNLOCK_CYC  = 500;
    localparam int CODE_LEN    = 4;
    localparam int MAX_FAILS   = 3;

    logic       clk, reset, enter, prog, relock;
    logic [3:0] digit;
    logic       locked, unlocked, error, lockout, prog_mode;
    logic [2:0] progress;
    logic [1:0] fail_cnt;

    int checks   = 0;
    int failures = 0;

    code_lock_param dut (
        .clk(clk), .reset(reset), .enter(enter), .digit(digit),
        .prog(prog), .relock(relock), .locked(locked), .unlocked(unlocked),
        .error(error), .lockout(lockout), .prog_mode(prog_mode),
        .progress(progress), .fail_cnt(fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: mode plus a queue of typed digits and absolute deadlines.
    typedef enum int {M_ENTRY, M_UNLOCKED, M_PROGRAM, M_LOCKOUT} mode_t;
    mode_t m_mode;
    int    m_buf[$];
    int    m_code[CODE_LEN];
    int    m_fails;
    int    m_deadline;
    bit    m_error;
    int    cyc;

    function automatic void model_reset();
        logic [15:0] defc;
        defc = 16'h1234;
        m_mode = M_ENTRY;
        m_buf.delete();
        for (int i = 0; i < CODE_LEN; i++) m_code[i] = int'(defc[(CODE_LEN-1-i)*4 +: 4]);
        m_fails = 0; m_deadline = 0; m_error = 1'b0; cyc = 0;
    endfunction

    function automatic void model_edge(bit en, int dg, bit pg, bit rl);
        bit ok;
        cyc++;
        m_error = 1'b0;
        case (m_mode)
            M_ENTRY: if (en) begin
                m_buf.push_back(dg);
                if (m_buf.size() == CODE_LEN) begin
                    ok = 1'b1;
                    for (int i = 0; i < CODE_LEN; i++) if (m_buf[i] != m_code[i]) ok = 1'b0;
                    m_buf.delete();
                    if (ok) begin
                        m_mode = M_UNLOCKED; m_fails = 0; m_deadline = cyc + UNLOCK_CYC;
                    end else begin
                        m_error = 1'b1; m_fails++;
                        if (m_fails == MAX_FAILS) begin
                            m_mode = M_LOCKOUT; m_deadline = cyc + LOCKOUT_CYC;
                        end
                    end
                end
            end
            M_LOCKOUT: if (cyc == m_deadline) begin
                m_mode = M_ENTRY; m_fails = 0;
            end
            M_UNLOCKED: begin
                if (rl || cyc == m_deadline) m_mode = M_ENTRY;
                else if (pg) begin m_mode = M_PROGRAM; m_buf.delete(); end
            end
            M_PROGRAM: begin
                if (rl) begin
                    m_mode = M_ENTRY; m_buf.delete();
                end else if (en) begin
                    m_buf.push_back(dg);
                    if (m_buf.size() == CODE_LEN) begin
                        for (int i = 0; i < CODE_LEN; i++) m_code[i] = m_buf[i];
                        m_buf.delete();
                        m_mode = M_UNLOCKED; m_deadline = cyc + UNLOCK_CYC;
                    end
                end
            end
        endcase
    endfunction

    // {locked, unlocked, error, lockout, prog_mode, progress[2:0], fail_cnt[1:0]}
    function automatic logic [9:0] model_vec();
        bit l;
        l = (m_mode == M_ENTRY) || (m_mode == M_LOCKOUT);
        return {l, !l, m_error, m_mode == M_LOCKOUT, m_mode == M_PROGRAM,
                3'(m_buf.size()), 2'(m_fails)};
    endfunction

    function automatic logic [9:0] dut_vec();
        return {locked, unlocked, error, lockout, prog_mode, progress, fail_cnt};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit en, input int dg, input bit pg, input bit rl);
        enter = en; digit = 4'(dg); prog = pg; relock = rl;
        @(posedge clk); #1;
        model_edge(en, dg, pg, rl);
        chk("model", 32'(dut_vec()), 32'(model_vec()));
        enter = 1'b0; prog = 1'b0; relock = 1'b0;
    endtask

    task automatic enter_code(input int a, input int b, input int c, input int d);
        step(1, a, 0, 0); step(1, b, 0, 0); step(1, c, 0, 0); step(1, d, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        chk("reset_async", 32'(dut_vec()), 32'(10'b10_0000_0000));
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit       en;
        int       dg;
        bit       pg;
        bit       rl;
        logic [9:0] exp;
    } vec_t;

    function automatic vec_t v(bit en, int dg, bit pg, bit rl, bit l, bit u, bit e,
                               bit pm, int p, int f);
        vec_t r;
        r.en = en; r.dg = dg; r.pg = pg; r.rl = rl;
        r.exp = {l, u, e, 1'b0, pm, 3'(p), 2'(f)};
        return r;
    endfunction

    vec_t vecs[$];
    int   n;

    initial begin
        reset = 1'b1; enter = 1'b0; prog = 1'b0; relock = 1'b0; digit = '0;
        model_reset();
        #12;
        chk("reset_state", 32'(dut_vec()), 32'(10'b10_0000_0000));
        @(posedge clk); #1;
        reset = 1'b0;

        //           en dg pg rl   l u e pm p f
        vecs.push_back(v(1, 1, 0, 0, 1, 0, 0, 0, 1, 0));
        vecs.push_back(v(1, 2, 0, 0, 1, 0, 0, 0, 2, 0));
        vecs.push_back(v(1, 3, 0, 0, 1, 0, 0, 0, 3, 0));
        vecs.push_back(v(1, 4, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(v(1, 7, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 0, 1, 0, 1, 0, 0));
        vecs.push_back(v(1, 9, 0, 0, 0, 1, 0, 1, 1, 0));
        vecs.push_back(v(1, 8, 0, 0, 0, 1, 0, 1, 2, 0));
        vecs.push_back(v(1, 7, 0, 0, 0, 1, 0, 1, 3, 0));
        vecs.push_back(v(1, 6, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 1, 0, 0, 1, 0, 0, 0, 1, 0));
        vecs.push_back(v(1, 2, 0, 0, 1, 0, 0, 0, 2, 0));
        vecs.push_back(v(1, 3, 0, 0, 1, 0, 0, 0, 3, 0));
        vecs.push_back(v(1, 4, 0, 0, 1, 0, 1, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
        vecs.push_back(v(1, 9, 0, 0, 1, 0, 0, 0, 1, 1));
        vecs.push_back(v(1, 8, 0, 0, 1, 0, 0, 0, 2, 1));
        vecs.push_back(v(1, 7, 0, 0, 1, 0, 0, 0, 3, 1));
        vecs.push_back(v(1, 6, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(v(1, 5, 0, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 1, 0, 0, 1, 0, 0, 0, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].en, vecs[i].dg, vecs[i].pg, vecs[i].rl);
            chk($sformatf("vec%0d", i), 32'(dut_vec()), 32'(vecs[i].exp));
        end

        // Wrong codes up to lockout, then measure the lockout length.
        do_reset();
        enter_code(1, 2, 3, 5);
        chk("wrong_error", 32'(error), 32'd1);
        chk("wrong_fails", 32'(fail_cnt), 32'd1);
        step(0, 0, 0, 0);
        chk("error_width", 32'(error), 32'd0);
        enter_code(5, 5, 5, 5);
        enter_code(0, 0, 0, 0);
        chk("lockout_enter", 32'(lockout), 32'd1);
        chk("lockout_fails", 32'(fail_cnt), 32'(MAX_FAILS));
        n = 0;
        while (lockout === 1'b1 && n < LOCKOUT_CYC + 20) begin
            step(1, (n % 4) + 1, n[0], n[1]);
            n++;
        end
        chk("lockout_len", 32'(n), 32'(LOCKOUT_CYC));
        chk("lockout_fail_clr", 32'(fail_cnt), 32'd0);
        enter_code(1, 2, 3, 4);
        chk("unlock_after_lockout", 32'(unlocked), 32'd1);

        // Auto-relock timing, then a relock pulse on the 10th unlocked cycle.
        n = 0;
        while (unlocked === 1'b1 && n < UNLOCK_CYC + 20) begin
            step(0, 0, 0, 0);
            n++;
        end
        chk("unlock_len", 32'(n), 32'(UNLOCK_CYC));
        enter_code(1, 2, 3, 4);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("relock_pulse", 32'(locked), 32'd1);

        // Programming freezes the timer; aborting keeps the old code.
        enter_code(1, 2, 3, 4);
        step(0, 0, 1, 0);
        for (int i = 0; i < UNLOCK_CYC + 100; i++) step(0, 0, 0, 0);
        chk("prog_frozen", 32'(prog_mode), 32'd1);
        step(1, 9, 0, 0); step(1, 8, 0, 0);
        step(0, 0, 0, 1);
        chk("prog_abort", 32'(locked), 32'd1);
        enter_code(1, 2, 3, 4);
        chk("code_kept", 32'(unlocked), 32'd1);
        step(0, 0, 0, 1);
        step(1, 1, 0, 0); step(1, 2, 0, 0);
        chk("partial", 32'(progress), 32'd2);
        do_reset();
        chk("reset_mid_progress", 32'(progress), 32'd0);
        enter_code(1, 2, 3, 4);
        chk("unlock_after_reset", 32'(unlocked), 32'd1);

        // Random traffic, digits biased toward the current code.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            bit en, pg, rl;
            int dg;
            en = ($urandom_range(0, 1) == 1);
            pg = ($urandom_range(0, 19) == 0);
            rl = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) != 0 && m_buf.size() < CODE_LEN)
                dg = (m_mode == M_PROGRAM) ? $urandom_range(0, 15) : m_code[m_buf.size()];
            else
                dg = $urandom_range(0, 15);
            step(en, dg, pg, rl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
